// File: rtl/w_bit_n_1_rr_mux.sv
// w_bit_n_1_rr_mux
// Registered N:1 stream multiplexer with round-robin arbitration and
// valid/ready handshakes on every input channel and on the output.
//
// Build option:
//   W_BIT_N_1_RR_MUX_FIXED_PRIO_EN - when defined, the rotating priority
//   pointer is removed and channel 0 always has highest priority.
//
// Parameters:
//   WIDTH - data bits per channel
//   N     - number of input channels (2..16)
//   SELW  - channel index width, derived from N
//
// Ports:
//   clk       - rising-edge clock
//   reset_n   - synchronous active-low reset
//   in_valid  - per-channel request, bit i = channel i
//   in_data   - channel i word at [i*WIDTH +: WIDTH]
//   in_ready  - per-channel accept, at most one bit high
//   out_valid - output register holds a word
//   out_data  - held word
//   out_sel   - index of the channel that supplied out_data
//   out_ready - sink accepts the held word
module w_bit_n_1_rr_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;

    logic             load_en;
    logic             found;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             in_xfer;

`ifndef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
`endif

    // Output register can take a new word when empty or being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Arbitration: walk channels starting at the priority pointer, wrapping at N-1.
    always_comb begin
        int unsigned idx;
        found      = 1'b0;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
`endif
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
                grant_data = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by reset_n so nothing is accepted during a reset cycle.
    assign in_ready = (reset_n && load_en) ? grant : '0;
    assign in_xfer  = reset_n && load_en && found;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifndef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
`ifndef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
            // Winner drops to lowest priority.
            ptr_d       = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifndef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifndef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_w_bit_n_1_rr_mux.sv
// Directed self-checking bench for w_bit_n_1_rr_mux (N=4, WIDTH=8).
// Expectations follow whichever arbitration build is selected by
// W_BIT_N_1_RR_MUX_FIXED_PRIO_EN.
module tb_w_bit_n_1_rr_mux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;
`ifdef W_BIT_N_1_RR_MUX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk;
    logic               reset_n;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    int vectors;
    int miscompares;

    w_bit_n_1_rr_mux #(
        .WIDTH(WIDTH),
        .N    (N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [SELW-1:0] s,
                             input logic [WIDTH-1:0] d);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
        check({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        logic [SELW-1:0] exp_sel;
        logic [SELW-1:0] rot [5];
        logic [SELW-1:0] alt [3];
        vectors     = 0;
        miscompares = 0;

        // Reset with every channel requesting.
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'h0);
        step();
        check("rst.in_ready2", 32'(in_ready), 32'h0);
        check_out("rst", 1'b0, 2'd0, 8'h00);

        // Rotation: 0,1,2,3,0 (fixed build: always 0).
        rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset_n = 1'b1;
        #1;
        check("rot.first_grant", 32'(in_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            exp_sel = FIXED ? 2'd0 : rot[i];
            check_out($sformatf("rot%0d", i), 1'b1, exp_sel, 8'hA0 + 8'(exp_sel));
        end
        // RR: ptr now 1. Load ch2 alone so ptr becomes 3.
        in_valid = 4'b0100;
        step();
        check_out("setptr", 1'b1, 2'd2, 8'hA2);

        // Wrap and skip: ptr=3, requests on 1 and 2.
        in_valid = 4'b0110;
        #1;
        check("wrap.in_ready", 32'(in_ready), 32'h2);
        step();
        check_out("wrap0", 1'b1, 2'd1, 8'hA1);
        check("wrap.in_ready2", 32'(in_ready), FIXED ? 32'h2 : 32'h4);
        step();
        check_out("wrap1", 1'b1, FIXED ? 2'd1 : 2'd2, FIXED ? 8'hA1 : 8'hA2);
        exp_sel = FIXED ? 2'd1 : 2'd2;

        // Backpressure: sink stalls 5 cycles with ch0 requesting.
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'h33};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
            step();
            check_out($sformatf("bp%0d", i), 1'b1, exp_sel, 8'hA0 + 8'(exp_sel));
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'h1);
        step();
        check_out("bp.reload", 1'b1, 2'd0, 8'h33);

        // Drain a single word from ch2.
        in_valid = 4'b0100;
        in_data  = {8'hA3, 8'h5C, 8'hA1, 8'h33};
        #1;
        check("drain.in_ready", 32'(in_ready), 32'h4);
        step();
        check_out("drain0", 1'b1, 2'd2, 8'h5C);
        in_valid = 4'b0000;
        step();
        check_out("drain1", 1'b0, 2'd2, 8'h5C);
        check("drain.in_ready2", 32'(in_ready), 32'h0);

        // Requests on 1 and 3: RR alternates, fixed always picks 1. RR ptr is 3 here.
        alt = '{2'd3, 2'd1, 2'd3};
        in_valid = 4'b1010;
        in_data  = {8'hD3, 8'hA2, 8'hD1, 8'hA0};
        for (int i = 0; i < 3; i++) begin
            step();
            exp_sel = FIXED ? 2'd1 : alt[i];
            check_out($sformatf("prio%0d", i), 1'b1, exp_sel, (exp_sel == 2'd1) ? 8'hD1 : 8'hD3);
        end

        // Reset mid-operation discards the held word and restores channel 0 priority.
        in_valid = 4'b1111;
        step();
        reset_n = 1'b0;
        #1;
        check("mrst.in_ready", 32'(in_ready), 32'h0);
        step();
        check_out("mrst", 1'b0, 2'd0, 8'h00);
        reset_n = 1'b1;
        #1;
        check("mrst.first_grant", 32'(in_ready), 32'h1);
        step();
        check_out("mrst.load", 1'b1, 2'd0, 8'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/w_bit_n_1_rr_mux.md
# w_bit_n_1_rr_mux

Registered N-input, WIDTH-bit multiplexer with round-robin arbitration and valid/ready handshakes on every channel. Generalises the single-bit 2:1 select element into a multi-channel stream selector: picks one requesting input per cycle, latches its data and channel index into an output register, and holds it until the sink accepts. Sits between multiple producer datapaths and one shared consumer (bus, ALU port, output stage).

## Interface
- WIDTH, 8, data bits per channel (≥1)
- N, 4, number of input channels (2..16)
- SELW, $clog2(N), width of channel index; derived, not overridden
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  N  per-channel request; bit i = channel i
- in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept; at most one bit high
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  selected word
- out_sel  output  SELW  index of channel that supplied out_data
- out_ready  input  1  sink accepts current word

## Operation
- Transfer on channel i when in_valid[i] && in_ready[i]; output transfer when out_valid && out_ready.
- load_en = !out_valid || out_ready. in_ready[i] = load_en && grant[i]; combinational from out_ready and in_valid.
- Round-robin: ptr (SELW bits) is highest-priority channel; grant = first i with in_valid[i] high, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. No grant if in_valid == 0.
- On an input transfer from channel g: out_data ← in_data[g], out_sel ← g, out_valid ← 1, ptr ← (g+1) mod N (g == N-1 wraps to 0).
- On output transfer with no input transfer: out_valid ← 0; out_data/out_sel hold last values.
- Simultaneous output and input transfer: register reloads same cycle, out_valid stays 1 (full throughput, 1 word/cycle).
- out_valid && !out_ready: out_data, out_sel, ptr frozen; in_ready == 0.
- Upstream rule: in_valid[i] and in_data[i] held stable until accepted; block does not check.
- ptr advances only on input transfer; losing channels keep priority order.
- N not a power of two: ptr never exceeds N-1; in_valid bits above N-1 do not exist.

## Timing
- Reset (reset_n low at posedge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 during reset cycle regardless of inputs.
- Reset mid-operation: held word discarded, no transfer occurs that cycle, priority returns to channel 0.
- Latency: input accepted at edge k → out_valid=1 with that data after edge k, available to sink in cycle k+1.
- One arbitration decision per cycle; no bubbles under continuous out_ready=1.
- Starvation bound: a channel holding in_valid waits at most N-1 accepted words from other channels.

## Configuration
- W_BIT_N_1_RR_MUX_FIXED_PRIO_EN defined: ptr removed; grant is fixed priority, lowest index wins (channel 0 highest); no starvation bound.
- Undefined (default): round-robin as above.
- Reset values, handshake, latency identical in both builds.

## Test plan
- Reset: reset_n=0 with in_valid=4'b1111, out_ready=1 → in_ready=0, out_valid=0, out_data=0, out_sel=0; after release first grant is channel 0.
- Round-robin rotation: N=4, WIDTH=8, in_valid=4'b1111 held, data ch i = 8'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0 with data A0,A1,A2,A3,A0, one word per cycle.
- Wrap and skip: ptr=3, in_valid=4'b0110 → grant ch1, ptr→2; next grant ch2, ptr→3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b0001 → in_ready=0, out_data/out_sel stable; out_ready=1 → same-cycle reload from ch0, out_valid stays 1.
- Drain: single word from ch2 (8'h5C), then in_valid=0, out_ready=1 → out_valid 1 for one cycle with out_sel=2, out_data=8'h5C, then 0.
- Fixed-priority build (macro defined): in_valid=4'b1010 held, out_ready=1 → ch1 granted every cycle, ch3 never granted.
